// File: rtl/iic_pkg.sv
// Shared definitions for the I2C/SCCB target and its companion master:
// OV13850 framing widths, default device address and the target FSM states.
package iic_pkg;

    localparam int unsigned REG_AW = 16;
    localparam int unsigned DW     = 8;

    localparam logic [6:0] IIC_DEV_ADDR = 7'b0010000;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_ACK_DEV,
        ST_REG_HI,
        ST_ACK_HI,
        ST_REG_LO,
        ST_ACK_LO,
        ST_WR_DATA,
        ST_ACK_WR,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } iic_state_e;

endpackage

// File: rtl/iic_target_regs_if.sv
// Bus pins and register-file port of the I2C target, bundled as one interface.
interface iic_target_regs_if;
    import iic_pkg::*;

    logic              scl_in;
    logic              sda_in;
    logic              sda_oe;
    logic              wr_valid;
    logic [REG_AW-1:0] wr_addr;
    logic [DW-1:0]     wr_data;
    logic [REG_AW-1:0] rd_addr;
    logic [DW-1:0]     rd_data;
    logic              busy;
    logic              addr_hit;

    // Target side.
    modport slave (
        input  scl_in, sda_in, rd_data,
        output sda_oe, wr_valid, wr_addr, wr_data, rd_addr, busy, addr_hit
    );

    // Environment side: pins, register bank / sensor model.
    modport master (
        output scl_in, sda_in, rd_data,
        input  sda_oe, wr_valid, wr_addr, wr_data, rd_addr, busy, addr_hit
    );

endinterface

// File: rtl/iic_pin_filter.sv
// Pin conditioner: 2-FF synchronizer, FILT_LEN-sample glitch filter and
// edge detection on the filtered level. Everything presets to 1 (idle bus).
module iic_pin_filter #(
    parameter int unsigned FILT_LEN = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    logic       filt_q,  filt_d;
    logic       prev_q,  prev_d;
    logic [3:0] cnt_q,   cnt_d;

    // Accept a new level only after FILT_LEN consecutive differing samples.
    always_comb begin
        sync1_d = pin;
        sync2_d = sync1_q;
        prev_d  = filt_q;
        filt_d  = filt_q;
        cnt_d   = '0;
        if (sync2_q != filt_q) begin
            if (cnt_q == 4'(FILT_LEN - 1)) begin
                filt_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // State registers, preset to the released-bus level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            filt_q  <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            filt_q  <= filt_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = filt_q;
    assign rise  = filt_q & ~prev_q;
    assign fall  = ~filt_q & prev_q;

endmodule

// File: rtl/iic_target_regs.sv
// I2C/SCCB target with OV13850 framing (7-bit device address, 16-bit
// auto-incrementing register pointer, 8-bit data) and a register-file port.
module iic_target_regs
    import iic_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = IIC_DEV_ADDR,
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned RD_LAT   = 2
) (
    input logic         clock,
    input logic         reset,
    iic_target_regs_if.slave bus
);

    if (FILT_LEN == 0 || FILT_LEN > 15) begin : g_bad_filt
        $error("FILT_LEN must be 1..15");
    end
    if (RD_LAT == 0 || RD_LAT > 4) begin : g_bad_lat
        $error("RD_LAT must be 1..4");
    end

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    iic_pin_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clock (clock),
        .reset (reset),
        .pin   (bus.scl_in),
        .level (scl_lvl),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    iic_pin_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clock (clock),
        .reset (reset),
        .pin   (bus.sda_in),
        .level (sda_lvl),
        .rise  (sda_rise),
        .fall  (sda_fall)
    );

    iic_state_e        state_q,    state_d;
    logic [2:0]        bit_cnt_q,  bit_cnt_d;
    logic [DW-1:0]     shift_q,    shift_d;
    logic [DW-1:0]     hi_q,       hi_d;
    logic [REG_AW-1:0] ptr_q,      ptr_d;
    logic              rw_q,       rw_d;
    logic              nack_q,     nack_d;
    logic              ph_q,       ph_d;
    logic              sda_oe_q,   sda_oe_d;
    logic              wr_valid_q, wr_valid_d;
    logic [REG_AW-1:0] wr_addr_q,  wr_addr_d;
    logic [DW-1:0]     wr_data_q,  wr_data_d;
    logic              busy_q,     busy_d;
    logic              addr_hit_q, addr_hit_d;

    logic          bus_start, bus_stop;
    logic [DW-1:0] rx_byte;
    logic          is_ack_state;

    assign bus_start    = sda_fall & scl_lvl;
    assign bus_stop     = sda_rise & scl_lvl;
    assign rx_byte      = {shift_q[6:0], sda_lvl};
    assign is_ack_state = (state_q == ST_ACK_DEV) || (state_q == ST_ACK_HI) ||
                          (state_q == ST_ACK_LO)  || (state_q == ST_ACK_WR);

    // Next-state and output computation; START/STOP take priority over all states.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        hi_d       = hi_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        nack_d     = nack_q;
        ph_d       = ph_q;
        sda_oe_d   = sda_oe_q;
        wr_valid_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        addr_hit_d = 1'b0;

        if (bus_start) begin
            state_d   = ST_DEV_ADDR;
            bit_cnt_d = '0;
            ph_d      = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (bus_stop) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            ph_d      = 1'b0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else if (is_ack_state) begin
            // ph_q separates the falling edge that starts the ACK slot from
            // the one that ends it (the rising edge between them sets it).
            if (scl_fall && !ph_q) begin
                sda_oe_d   = 1'b1;
                addr_hit_d = (state_q == ST_ACK_DEV);
            end else if (scl_rise) begin
                ph_d = 1'b1;
            end else if (scl_fall && ph_q) begin
                ph_d      = 1'b0;
                bit_cnt_d = '0;
                sda_oe_d  = 1'b0;
                case (state_q)
                    ST_ACK_DEV: begin
                        if (rw_q) begin
                            state_d  = ST_RD_DATA;
                            shift_d  = bus.rd_data;
                            sda_oe_d = ~bus.rd_data[7];
                        end else begin
                            state_d = ST_REG_HI;
                        end
                    end
                    ST_ACK_HI: state_d = ST_REG_LO;
                    ST_ACK_LO: begin
                        state_d = ST_WR_DATA;
                        ptr_d   = {hi_q, shift_q};
                    end
                    default: begin
                        state_d = ST_WR_DATA;
                        ptr_d   = ptr_q + 16'd1;
                    end
                endcase
            end
        end else begin
            case (state_q)
                ST_DEV_ADDR, ST_REG_HI, ST_REG_LO, ST_WR_DATA: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            ph_d = 1'b0;
                            case (state_q)
                                ST_DEV_ADDR: begin
                                    rw_d    = sda_lvl;
                                    state_d = (rx_byte[7:1] == DEV_ADDR) ? ST_ACK_DEV : ST_IGNORE;
                                end
                                ST_REG_HI: begin
                                    hi_d    = rx_byte;
                                    state_d = ST_ACK_HI;
                                end
                                ST_REG_LO: state_d = ST_ACK_LO;
                                default: begin
                                    wr_valid_d = 1'b1;
                                    wr_addr_d  = ptr_q;
                                    wr_data_d  = rx_byte;
                                    state_d    = ST_ACK_WR;
                                end
                            endcase
                        end
                    end
                end
                ST_RD_DATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_RD_ACK;
                            ph_d    = 1'b0;
                        end
                    end else if (scl_fall) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                ST_RD_ACK: begin
                    // Pointer advances on the ACK clock so rd_data has the
                    // whole SCL high phase to settle before the next load.
                    if (scl_fall && !ph_q) begin
                        sda_oe_d = 1'b0;
                    end else if (scl_rise) begin
                        ph_d   = 1'b1;
                        nack_d = sda_lvl;
                        ptr_d  = ptr_q + 16'd1;
                    end else if (scl_fall && ph_q) begin
                        ph_d      = 1'b0;
                        bit_cnt_d = '0;
                        if (!nack_q) begin
                            state_d  = ST_RD_DATA;
                            shift_d  = bus.rd_data;
                            sda_oe_d = ~bus.rd_data[7];
                        end else begin
                            state_d  = ST_IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_IGNORE: sda_oe_d = 1'b0;
                ST_IDLE:   sda_oe_d = 1'b0;
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // FSM and registered outputs; async reset releases SDA immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            hi_q       <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            nack_q     <= 1'b0;
            ph_q       <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            addr_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            hi_q       <= hi_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            nack_q     <= nack_d;
            ph_q       <= ph_d;
            sda_oe_q   <= sda_oe_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            addr_hit_q <= addr_hit_d;
        end
    end

    assign bus.sda_oe   = sda_oe_q;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.rd_addr  = ptr_q;
    assign bus.busy     = busy_q;
    assign bus.addr_hit = addr_hit_q;

endmodule

// File: tb/tb_iic_target_regs.sv
// Bench for iic_target_regs: bit-banged I2C master, register model with
// two-cycle read latency, and a write scoreboard checked by a monitor.
module tb_iic_target_regs;
    import iic_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;
    logic sda_line;

    int checks   = 0;
    int failures = 0;
    int hit_cnt  = 0;
    int oe_seen  = 0;

    logic [23:0] exp_q[$];
    logic [7:0]  rd_p0, rd_p1;

    always #5 clock = ~clock;

    iic_target_regs_if bus();

    assign sda_line    = sda_m & ~bus.sda_oe;
    assign bus.scl_in  = scl_m;
    assign bus.sda_in  = sda_line;
    assign bus.rd_data = rd_p1;

    iic_target_regs #(
        .DEV_ADDR (7'b0010000),
        .FILT_LEN (4),
        .RD_LAT   (2)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [7:0] reg_model(input logic [15:0] a);
        case (a)
            16'h300A: return 8'h8A;
            16'h300B: return 8'h50;
            default:  return a[7:0] ^ 8'hC3;
        endcase
    endfunction

    // Register bank model: contents appear two cycles after rd_addr.
    always_ff @(posedge clock) begin
        rd_p0 <= reg_model(bus.rd_addr);
        rd_p1 <= rd_p0;
    end

    // Monitor: every wr_valid pops the scoreboard; also counts hits and SDA drive.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.wr_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL wr_unexpected actual=%h_%h required=none", bus.wr_addr, bus.wr_data);
                end else begin
                    logic [23:0] e;
                    e = exp_q.pop_front();
                    if ({bus.wr_addr, bus.wr_data} !== e) begin
                        failures++;
                        $display("FAIL wr_value actual=%h_%h required=%h_%h",
                                 bus.wr_addr, bus.wr_data, e[23:8], e[7:0]);
                    end
                end
            end
            if (bus.addr_hit) hit_cnt++;
            if (bus.sda_oe) oe_seen = 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic qtr();
        repeat (10) @(posedge clock);
    endtask

    task automatic start_cond();
        if (scl_m == 1'b0) begin
            sda_m = 1'b1; qtr();
            scl_m = 1'b1; qtr();
        end
        sda_m = 1'b0; qtr();
        scl_m = 1'b0; qtr();
    endtask

    task automatic stop_cond();
        sda_m = 1'b0; qtr();
        scl_m = 1'b1; qtr();
        sda_m = 1'b1; qtr();
    endtask

    // Master-driven bit; optional 1-cycle SDA and 2-cycle SCL glitches while SCL is high.
    task automatic write_bit(input logic b, input bit glitch);
        sda_m = b; qtr();
        scl_m = 1'b1;
        if (glitch) begin
            repeat (3) @(posedge clock);
            sda_m = ~b; @(posedge clock);
            sda_m = b;  repeat (3) @(posedge clock);
            scl_m = 1'b0; repeat (2) @(posedge clock);
            scl_m = 1'b1; repeat (11) @(posedge clock);
        end else begin
            qtr(); qtr();
        end
        scl_m = 1'b0; qtr();
    endtask

    task automatic read_bit(output logic b);
        sda_m = 1'b1; qtr();
        scl_m = 1'b1; qtr();
        b = sda_line; qtr();
        scl_m = 1'b0; qtr();
    endtask

    task automatic write_byte(input logic [7:0] v, input bit glitch, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(v[i], glitch);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] v, input logic mack);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
        write_bit(mack, 1'b0);
    endtask

    // Write transaction; each data byte pushes its expected register write.
    task automatic wr_xfer(input string tag, input logic [15:0] a, input logic [7:0] d0,
                           input logic [7:0] d1, input int n, input bit glitch);
        logic ack;
        start_cond();
        write_byte(8'h20, glitch, ack); chk({tag, "_ack_dev"}, ack, 0);
        chk({tag, "_busy"}, bus.busy, 1);
        write_byte(a[15:8], glitch, ack); chk({tag, "_ack_hi"}, ack, 0);
        write_byte(a[7:0], glitch, ack);  chk({tag, "_ack_lo"}, ack, 0);
        exp_q.push_back({a, d0});
        write_byte(d0, glitch, ack); chk({tag, "_ack_d0"}, ack, 0);
        if (n > 1) begin
            exp_q.push_back({a + 16'd1, d1});
            write_byte(d1, glitch, ack); chk({tag, "_ack_d1"}, ack, 0);
        end
        stop_cond();
        chk({tag, "_busy_stop"}, bus.busy, 0);
        chk({tag, "_wrq_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       ack;
        logic [7:0] v;
        int         h0;
        bit         found;

        repeat (5) @(posedge clock);
        #1;
        chk("rst_sda_oe",   bus.sda_oe,   0);
        chk("rst_wr_valid", bus.wr_valid, 0);
        chk("rst_wr_addr",  bus.wr_addr,  0);
        chk("rst_wr_data",  bus.wr_data,  0);
        chk("rst_rd_addr",  bus.rd_addr,  0);
        chk("rst_busy",     bus.busy,     0);
        chk("rst_addr_hit", bus.addr_hit, 0);
        reset = 1'b0;
        repeat (20) @(posedge clock);

        // Single write 0x10 -> 0x3012.
        h0 = hit_cnt;
        wr_xfer("t1", 16'h3012, 8'h10, 8'h00, 1, 1'b0);
        chk("t1_hits", hit_cnt - h0, 1);
        chk("t1_rd_addr", bus.rd_addr, 16'h3013);

        // Burst across the pointer wrap.
        wr_xfer("t2", 16'hFFFF, 8'h5A, 8'hA5, 2, 1'b0);
        chk("t2_rd_addr", bus.rd_addr, 16'h0001);

        // Pointer write, repeated START, two-byte read.
        start_cond();
        write_byte(8'h20, 1'b0, ack); chk("t3_ack_dev", ack, 0);
        write_byte(8'h30, 1'b0, ack); chk("t3_ack_hi", ack, 0);
        write_byte(8'h0A, 1'b0, ack); chk("t3_ack_lo", ack, 0);
        start_cond();
        chk("t3_busy_sr", bus.busy, 1);
        write_byte(8'h21, 1'b0, ack); chk("t3_ack_rd", ack, 0);
        read_byte(v, 1'b0); chk("t3_rd0", v, 8'h8A);
        read_byte(v, 1'b1); chk("t3_rd1", v, 8'h50);
        chk("t3_release", bus.sda_oe, 0);
        chk("t3_rd_addr", bus.rd_addr, 16'h300C);
        stop_cond();
        chk("t3_busy_stop", bus.busy, 0);

        // Foreign device address 0x21: nothing may respond.
        h0 = hit_cnt;
        oe_seen = 0;
        start_cond();
        write_byte(8'h42, 1'b0, ack); chk("t4_nack_dev", ack, 1);
        write_byte(8'h30, 1'b0, ack); chk("t4_nack_b1", ack, 1);
        write_byte(8'h12, 1'b0, ack);
        write_byte(8'h55, 1'b0, ack); chk("t4_nack_b3", ack, 1);
        chk("t4_hits", hit_cnt - h0, 0);
        stop_cond();
        chk("t4_oe_seen", oe_seen, 0);
        chk("t4_rd_addr", bus.rd_addr, 16'h300C);

        // Glitches on every master-driven bit.
        h0 = hit_cnt;
        wr_xfer("t5", 16'h1234, 8'hC3, 8'h00, 1, 1'b1);
        chk("t5_hits", hit_cnt - h0, 1);
        chk("t5_rd_addr", bus.rd_addr, 16'h1235);

        // Reset mid-read while the target pulls SDA low.
        start_cond();
        write_byte(8'h21, 1'b0, ack); chk("t6_ack_rd", ack, 0);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            sda_m = 1'b1; qtr();
            scl_m = 1'b1; qtr();
            if (bus.sda_oe) found = 1'b1;
            else begin qtr(); scl_m = 1'b0; qtr(); end
        end
        chk("t6_oe_found", found, 1);
        reset = 1'b1;
        #1;
        chk("t6_rst_oe", bus.sda_oe, 0);
        chk("t6_rst_busy", bus.busy, 0);
        scl_m = 1'b1;
        sda_m = 1'b1;
        repeat (10) @(posedge clock);
        reset = 1'b0;
        repeat (20) @(posedge clock);
        chk("t6_rd_addr_rst", bus.rd_addr, 0);
        wr_xfer("t6", 16'h0100, 8'h77, 8'h00, 1, 1'b0);

        repeat (20) @(posedge clock);
        chk("final_wrq_drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
